otter_io_periph: RTL
====================

OTTER_IO_PERIPH -- requirements
Module: otter_io_periph

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized BTN samples required to change the debounced button state.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 IOBUS_ADDR  in  32  MCU I/O address.
REQ-005 IOBUS_OUT  in  32  MCU write data.
REQ-006 IOBUS_WR  in  1  write strobe; the write commits on the same rising edge.
REQ-007 IOBUS_IN  out  32  read data returned to the MCU.
REQ-008 INTR  out  1  interrupt request to the MCU, level, registered.
REQ-009 SWITCHES  in  16  asynchronous board switches.
REQ-010 BTN  in  1  asynchronous interrupt button.
REQ-011 LEDS  out  16  board LEDs, registered.

Function
REQ-012 Address map:
- 0x11008000 SW, RO: {16'b0, sw_sync}
- 0x1100C000 LED, RW: bits[15:0]
- 0x11010000 TCTRL, RW: bit0 TEN, bit1 TIE, bit2 BIE; other bits read 0
- 0x11010004 TLOAD, RW: 32-bit
- 0x11010008 TCOUNT, RO
- 0x1101000C ISTAT, RW1C: bit0 TFLAG, bit1 BFLAG
REQ-013 Reads are combinational from IOBUS_ADDR, independent of IOBUS_WR; unmapped addresses read 0.
REQ-014 Writes to unmapped or RO addresses have no effect.
REQ-015 SWITCHES pass through a 2-flop synchronizer; a switch change is visible on SW 2 cycles later.
REQ-016 BTN pass through a 2-flop synchronizer, then the debounce logic.
REQ-017 Debounce: a counter increments while the synchronized sample differs from the debounced state and resets to 0 when they match; at DEBOUNCE_CYCLES the debounced state toggles and the counter clears.
REQ-018 A 0->1 transition of the debounced button sets BFLAG; a 1->0 transition does not.
REQ-019 Timer when TEN=1:
- TCOUNT != 0: TCOUNT decrements by 1.
- TCOUNT == 0: TFLAG is set and TCOUNT reloads from TLOAD.
REQ-020 Timer when TEN=0: TCOUNT holds its value.
REQ-021 TLOAD=0 with TEN=1 sets TFLAG every cycle.
REQ-022 A write to TLOAD also loads TCOUNT with the written value, and takes priority over decrement or reload in that cycle.
REQ-023 A write to ISTAT clears each flag whose write-data bit is 1.
REQ-024 If a flag-set event and its W1C occur in the same cycle, the set wins and the flag remains 1.
REQ-025 INTR is a register updated each cycle to (TFLAG & TIE) | (BFLAG & BIE); INTR therefore lags flag or enable changes by 1 cycle.
REQ-026 INTR stays asserted until software clears the enabled flags or disables the interrupt enables; clearing takes effect on INTR 1 cycle after the register update.
REQ-027 TCOUNT wraps never: decrement stops at 0 and reload occurs instead; no underflow.
REQ-028 Writes to TCTRL take effect from the next cycle: the timer does not act on the new TEN value in the write cycle itself.

Reset
REQ-029 With RST=1 at a clock edge, the following clear to 0: LEDS, TCTRL, TLOAD, TCOUNT, ISTAT, INTR, both synchronizers, the debounce counter and the debounced state.
REQ-030 RST overrides any simultaneous IOBUS_WR.
REQ-031 RST mid-count or mid-debounce discards all progress.

Verification
REQ-032 LED write: write 0x0000A5A5 to 0x1100C000 -> LEDS=0xA5A5 next cycle; readback returns 0x0000A5A5; a write to 0x11008000 leaves SW unchanged.
REQ-033 Timer: TLOAD=3, TCTRL=0x3 -> TFLAG set 4 cycles after enable, then every 4 cycles; INTR high 1 cycle after TFLAG; W1C 0x1 -> INTR low 2 cycles later.
REQ-034 Debounce, DEBOUNCE_CYCLES=4:
- BTN high 3 cycles then low -> BFLAG stays 0.
- BTN held high -> BFLAG=1 at cycle 2+4+1 after the edge.
- BIE=0 -> INTR stays 0.
REQ-035 Simultaneous set/clear: TLOAD=0, TEN=1, W1C ISTAT=0x1 -> TFLAG reads 1.
REQ-036 Reset mid-count: TLOAD=100, timer running, pulse RST -> TCOUNT=0, TCTRL=0, INTR=0, LEDS=0 the next cycle; a read of an unmapped address 0x11020000 returns 0.

Source files
------------

// File: rtl/otter_io_periph.sv
// OTTER MCU I/O peripheral: switches, LEDs, down-counting timer and a debounced
// interrupt button, with a level interrupt request back to the MCU.
module otter_io_periph #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR,
  input  logic [15:0] SWITCHES,
  input  logic        BTN,
  output logic [15:0] LEDS
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [31:0] ADDR_SW     = 32'h1100_8000;
  localparam logic [31:0] ADDR_LED    = 32'h1100_C000;
  localparam logic [31:0] ADDR_TCTRL  = 32'h1101_0000;
  localparam logic [31:0] ADDR_TLOAD  = 32'h1101_0004;
  localparam logic [31:0] ADDR_TCOUNT = 32'h1101_0008;
  localparam logic [31:0] ADDR_ISTAT  = 32'h1101_000C;

  logic [15:0]      sw_meta, sw_sync;
  logic             btn_meta, btn_sync;
  logic [CNT_W-1:0] db_cnt, db_cnt_n, db_cnt_inc;
  logic             db_state, db_state_n, db_prev;
  logic [2:0]       tctrl, tctrl_n;
  logic [31:0]      tload, tload_n, tcount, tcount_n;
  logic             tflag, tflag_n, bflag, bflag_n, intr_n;
  logic [15:0]      leds_n;
  logic             tflag_set, bflag_set;
  logic             wr_led, wr_tctrl, wr_tload, wr_istat;

  // Next-state logic for all architectural registers
  always_comb begin
    db_cnt_n   = db_cnt;
    db_state_n = db_state;
    tctrl_n    = tctrl;
    tload_n    = tload;
    tcount_n   = tcount;
    leds_n     = LEDS;
    tflag_set  = 1'b0;
    bflag_set  = db_state & ~db_prev;
    db_cnt_inc = db_cnt + CNT_W'(1);

    wr_led   = IOBUS_WR && (IOBUS_ADDR == ADDR_LED);
    wr_tctrl = IOBUS_WR && (IOBUS_ADDR == ADDR_TCTRL);
    wr_tload = IOBUS_WR && (IOBUS_ADDR == ADDR_TLOAD);
    wr_istat = IOBUS_WR && (IOBUS_ADDR == ADDR_ISTAT);

    if (wr_led)   leds_n  = IOBUS_OUT[15:0];
    if (wr_tctrl) tctrl_n = IOBUS_OUT[2:0];
    if (wr_tload) tload_n = IOBUS_OUT;

    // Debounce: count consecutive disagreeing samples, flip state at threshold
    if (btn_sync != db_state) begin
      if (db_cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
        db_state_n = ~db_state;
        db_cnt_n   = '0;
      end else begin
        db_cnt_n = db_cnt_inc;
      end
    end else begin
      db_cnt_n = '0;
    end

    // Timer acts on the registered TEN, so a TCTRL write only matters next cycle
    if (wr_tload) begin
      tcount_n = IOBUS_OUT;
    end else if (tctrl[0]) begin
      if (tcount != 32'd0) begin
        tcount_n = tcount - 32'd1;
      end else begin
        tcount_n  = tload;
        tflag_set = 1'b1;
      end
    end

    // Set beats a simultaneous write-one-to-clear
    tflag_n = (tflag & ~(wr_istat & IOBUS_OUT[0])) | tflag_set;
    bflag_n = (bflag & ~(wr_istat & IOBUS_OUT[1])) | bflag_set;
    intr_n  = (tflag & tctrl[1]) | (bflag & tctrl[2]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      db_cnt   <= '0;
      db_state <= 1'b0;
      db_prev  <= 1'b0;
      tctrl    <= '0;
      tload    <= '0;
      tcount   <= '0;
      tflag    <= 1'b0;
      bflag    <= 1'b0;
      INTR     <= 1'b0;
      LEDS     <= '0;
    end else begin
      sw_meta  <= SWITCHES;
      sw_sync  <= sw_meta;
      btn_meta <= BTN;
      btn_sync <= btn_meta;
      db_cnt   <= db_cnt_n;
      db_state <= db_state_n;
      db_prev  <= db_state;
      tctrl    <= tctrl_n;
      tload    <= tload_n;
      tcount   <= tcount_n;
      tflag    <= tflag_n;
      bflag    <= bflag_n;
      INTR     <= intr_n;
      LEDS     <= leds_n;
    end
  end

  // Combinational read mux; unmapped addresses return zero
  always_comb begin
    IOBUS_IN = 32'd0;
    case (IOBUS_ADDR)
      ADDR_SW:     IOBUS_IN = {16'd0, sw_sync};
      ADDR_LED:    IOBUS_IN = {16'd0, LEDS};
      ADDR_TCTRL:  IOBUS_IN = {29'd0, tctrl};
      ADDR_TLOAD:  IOBUS_IN = tload;
      ADDR_TCOUNT: IOBUS_IN = tcount;
      ADDR_ISTAT:  IOBUS_IN = {30'd0, bflag, tflag};
      default:     IOBUS_IN = 32'd0;
    endcase
  end

endmodule
